// File: rtl/des_pkg.sv
// Shared definitions for the DES key schedule: the PC-1 / PC-2 selection
// tables, the per-round left-shift schedule, the FSM state type and the
// datapath widths. Table entries use DES bit numbering (1 = MSB).
package des_pkg;

  localparam int KEY_W = 64;
  localparam int CD_W  = 28;
  localparam int RK_W  = 48;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GEN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // PC-1: 64-bit key (parity bits dropped) -> 56-bit {C0, D0}
  localparam int PC1 [56] = '{
    57, 49, 41, 33, 25, 17,  9,
     1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27,
    19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,
     7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29,
    21, 13,  5, 28, 20, 12,  4
  };

  // PC-2: 56-bit {C, D} -> 48-bit round key
  localparam int PC2 [48] = '{
    14, 17, 11, 24,  1,  5,
     3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8,
    16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55,
    30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53,
    46, 42, 50, 36, 29, 32
  };

  // Left-rotate amount of round r+1 is SHIFT[r] (0-based index).
  localparam logic [1:0] SHIFT [16] = '{
    2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
    2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1
  };

endpackage

// File: rtl/des_pc2.sv
// DES Permuted Choice 2: combinational selection of 48 of the 56 C/D bits.
// Ports:
//   cd        in  56  {C, D}, C in the upper 28 bits
//   round_key out 48  permuted round key
module des_pc2
  import des_pkg::*;
(
  input  logic [2*CD_W-1:0] cd,
  output logic [RK_W-1:0]   round_key
);

  always_comb begin
    round_key = '0;
    for (int i = 0; i < RK_W; i++) begin
      round_key[RK_W-1-i] = cd[2*CD_W - PC2[i]];
    end
  end

endmodule

// File: rtl/des_key_scheduler.sv
// Iterative DES key schedule. Loads one 64-bit key and presents the 16
// round keys one at a time over a valid/ready handshake, K1..K16 for
// encryption or K16..K1 for decryption.
// Ports:
//   clk        in   1  system clock, rising edge
//   n_rst      in   1  asynchronous active-low reset
//   key_in     in  64  DES key (parity bits ignored)
//   load       in   1  start request, honoured only in IDLE
//   decrypt    in   1  direction, captured with load
//   key_ready  in   1  consumer accepts round_key this cycle
//   round_key  out 48  current round key (registered)
//   key_valid  out  1  round_key is valid
//   round_num  out  4  position of the presented key in the sequence
//   busy       out  1  sequence in progress
//   done       out  1  one-cycle pulse after the last key transfers
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for load; outputs idle
// GEN   | presenting round keys, advancing on each accepted transfer
// DONE  | one-cycle done pulse, then back to IDLE
module des_key_scheduler
  import des_pkg::*;
#(
  parameter int NUM_ROUNDS = 16
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic [KEY_W-1:0] key_in,
  input  logic             load,
  input  logic             decrypt,
  input  logic             key_ready,
  output logic [RK_W-1:0]  round_key,
  output logic             key_valid,
  output logic [3:0]       round_num,
  output logic             busy,
  output logic             done
);

  localparam logic [3:0] LAST_ROUND = 4'(NUM_ROUNDS - 1);

  state_t            state;
  logic [CD_W-1:0]   c_q;
  logic [CD_W-1:0]   d_q;
  logic              dec_q;
  logic [2*CD_W-1:0] pc1_cd;
  logic [CD_W-1:0]   c_nxt;
  logic [CD_W-1:0]   d_nxt;
  logic [RK_W-1:0]   pc2_key;
  logic              xfer;
  logic [3:0]        enc_idx;
  logic [3:0]        dec_idx;

  function automatic logic [CD_W-1:0] rotl(input logic [CD_W-1:0] x, input logic [1:0] n);
    rotl = (n == 2'd2) ? {x[CD_W-3:0], x[CD_W-1:CD_W-2]} : {x[CD_W-2:0], x[CD_W-1]};
  endfunction

  function automatic logic [CD_W-1:0] rotr(input logic [CD_W-1:0] x, input logic [1:0] n);
    rotr = (n == 2'd2) ? {x[1:0], x[CD_W-1:2]} : {x[0], x[CD_W-1:1]};
  endfunction

  // PC-1: DES bit p of the key lives at key_in[64-p].
  always_comb begin
    pc1_cd = '0;
    for (int i = 0; i < 2*CD_W; i++) begin
      pc1_cd[2*CD_W-1-i] = key_in[KEY_W - PC1[i]];
    end
  end

  assign xfer = key_valid && key_ready;

  // Encrypt: presenting K(n+1), next needs the shift of round n+2.
  // Decrypt: presenting K(16-n) built from C(16-n); undoing that round's
  // shift gives C(15-n).
  assign enc_idx = round_num + 4'd1;
  assign dec_idx = LAST_ROUND - round_num;

  always_comb begin
    c_nxt = c_q;
    d_nxt = d_q;
    if (state == IDLE) begin
      if (decrypt) begin
        // C16/D16 equal C0/D0 after the full 28-bit rotation.
        c_nxt = pc1_cd[2*CD_W-1:CD_W];
        d_nxt = pc1_cd[CD_W-1:0];
      end else begin
        c_nxt = rotl(pc1_cd[2*CD_W-1:CD_W], SHIFT[0]);
        d_nxt = rotl(pc1_cd[CD_W-1:0], SHIFT[0]);
      end
    end else if (dec_q) begin
      c_nxt = rotr(c_q, SHIFT[dec_idx]);
      d_nxt = rotr(d_q, SHIFT[dec_idx]);
    end else begin
      c_nxt = rotl(c_q, SHIFT[enc_idx]);
      d_nxt = rotl(d_q, SHIFT[enc_idx]);
    end
  end

  des_pc2 u_pc2 (
    .cd        ({c_nxt, d_nxt}),
    .round_key (pc2_key)
  );

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state     <= IDLE;
      c_q       <= '0;
      d_q       <= '0;
      dec_q     <= 1'b0;
      round_key <= '0;
      key_valid <= 1'b0;
      round_num <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (load) begin
            c_q       <= c_nxt;
            d_q       <= d_nxt;
            dec_q     <= decrypt;
            round_key <= pc2_key;
            key_valid <= 1'b1;
            busy      <= 1'b1;
            round_num <= '0;
            state     <= GEN;
          end
        end
        GEN: begin
          if (xfer) begin
            if (round_num == LAST_ROUND) begin
              key_valid <= 1'b0;
              busy      <= 1'b0;
              done      <= 1'b1;
              round_num <= '0;
              state     <= DONE;
            end else begin
              c_q       <= c_nxt;
              d_q       <= d_nxt;
              round_key <= pc2_key;
              round_num <= round_num + 4'd1;
            end
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_des_key_scheduler.sv
module tb_des_key_scheduler;

  typedef logic [47:0] ks_t [16];

  localparam logic [63:0] KV  = 64'h133457799BBCDFF1;
  localparam logic [47:0] K1  = 48'h1B02EFFC7072;
  localparam logic [47:0] K2  = 48'h79AED9DBC9E5;
  localparam logic [47:0] K16 = 48'hCB3D8B0E17F5;

  localparam int PC1_T [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
  };
  localparam int PC2_T [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
  };
  localparam int SH_T [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

  logic        clk;
  logic        n_rst;
  logic [63:0] key_in;
  logic        load;
  logic        decrypt;
  logic        key_ready;
  logic [47:0] round_key;
  logic        key_valid;
  logic [3:0]  round_num;
  logic        busy;
  logic        done;

  int vectors = 0;
  int miscompares = 0;
  ks_t got;
  ks_t enc_got;

  des_key_scheduler #(.NUM_ROUNDS(16)) dut (
    .clk       (clk),
    .n_rst     (n_rst),
    .key_in    (key_in),
    .load      (load),
    .decrypt   (decrypt),
    .key_ready (key_ready),
    .round_key (round_key),
    .key_valid (key_valid),
    .round_num (round_num),
    .busy      (busy),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: each Ci/Di is C0/D0 rotated left by the cumulative shift.
  function automatic ks_t model(input logic [63:0] key);
    ks_t         ks;
    logic [1:56] cd0;
    logic [1:28] c0, d0, cr, dr;
    int          tot;
    int          pos;
    for (int p = 1; p <= 56; p++) cd0[p] = key[64 - PC1_T[p-1]];
    c0  = cd0[1:28];
    d0  = cd0[29:56];
    tot = 0;
    for (int r = 0; r < 16; r++) begin
      tot = tot + SH_T[r];
      for (int p = 1; p <= 28; p++) begin
        cr[p] = c0[((p - 1 + tot) % 28) + 1];
        dr[p] = d0[((p - 1 + tot) % 28) + 1];
      end
      for (int j = 1; j <= 48; j++) begin
        pos = PC2_T[j-1];
        ks[r][48-j] = (pos <= 28) ? cr[pos] : dr[pos-28];
      end
    end
    return ks;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // mode 0: ready held high, 1: ready pattern 1,0,0,1,..., 2: random ready.
  // A load with a different key and flipped decrypt is pulsed mid-run.
  task automatic run_seq(input logic [63:0] key, input logic dec, input int mode,
                         input logic [63:0] ref_key);
    ks_t         exp_k;
    int          xfers;
    int          cyc;
    int          idx;
    logic        rdy;
    logic        stalled;
    logic [47:0] pk;
    logic [3:0]  pn;
    exp_k   = model(ref_key);
    key_in  = key;
    decrypt = dec;
    load    = 1'b1;
    @(posedge clk); #1;
    load    = 1'b0;
    key_in  = {$urandom, $urandom};
    check("busy_after_load", 64'(busy), 64'd1);
    xfers   = 0;
    cyc     = 0;
    stalled = 1'b0;
    pk      = '0;
    pn      = '0;
    while (xfers < 16 && cyc < 200) begin
      if (stalled) begin
        check("stall_key_hold", 64'(round_key), 64'(pk));
        check("stall_num_hold", 64'(round_num), 64'(pn));
      end
      check("valid_in_gen", 64'(key_valid), 64'd1);
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = ((cyc % 4) == 0) || ((cyc % 4) == 3);
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      key_ready = rdy;
      if (cyc == 3) begin
        load    = 1'b1;
        key_in  = {$urandom, $urandom};
        decrypt = ~dec;
      end else begin
        load = 1'b0;
      end
      if (key_valid && rdy) begin
        idx = dec ? 15 - xfers : xfers;
        check("round_num", 64'(round_num), 64'(xfers));
        check("round_key", 64'(round_key), 64'(exp_k[idx]));
        got[xfers] = round_key;
        xfers++;
        stalled = 1'b0;
      end else begin
        stalled = key_valid;
        pk      = round_key;
        pn      = round_num;
      end
      @(posedge clk); #1;
      cyc++;
    end
    load      = 1'b0;
    key_ready = 1'b0;
    check("transfer_count", 64'(xfers), 64'd16);
    check("done_pulse", 64'(done), 64'd1);
    check("busy_clear", 64'(busy), 64'd0);
    check("valid_clear", 64'(key_valid), 64'd0);
    check("num_return0", 64'(round_num), 64'd0);
    // load during the DONE cycle must not start a new run
    load   = 1'b1;
    key_in = {$urandom, $urandom};
    @(posedge clk); #1;
    load   = 1'b0;
    check("done_one_cycle", 64'(done), 64'd0);
    check("load_in_done_ignored", 64'(key_valid), 64'd0);
    check("idle_not_busy", 64'(busy), 64'd0);
  endtask

  initial begin
    logic [63:0] rk;
    logic        rd;
    n_rst     = 1'b0;
    load      = 1'b0;
    decrypt   = 1'b0;
    key_ready = 1'b0;
    key_in    = '0;
    #12;
    check("rst_round_key", 64'(round_key), 64'd0);
    check("rst_key_valid", 64'(key_valid), 64'd0);
    check("rst_round_num", 64'(round_num), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    n_rst = 1'b1;
    @(posedge clk); #1;

    // known-answer encrypt run
    run_seq(KV, 1'b0, 0, KV);
    check("kat_k1", 64'(got[0]), 64'(K1));
    check("kat_k2", 64'(got[1]), 64'(K2));
    check("kat_k16", 64'(got[15]), 64'(K16));
    enc_got = got;

    // decrypt run is the encrypt run reversed
    run_seq(KV, 1'b1, 0, KV);
    check("dec_first", 64'(got[0]), 64'(K16));
    check("dec_last", 64'(got[15]), 64'(K1));
    for (int i = 0; i < 16; i++) check("dec_reverse", 64'(got[i]), 64'(enc_got[15-i]));

    // backpressure
    run_seq(KV, 1'b0, 1, KV);

    // parity bit 64 flipped gives identical keys
    run_seq(KV ^ 64'h1, 1'b0, 1, KV);
    for (int i = 0; i < 16; i++) check("parity_ignored", 64'(got[i]), 64'(enc_got[i]));

    // abort mid-GEN after 5 transfers
    key_in  = KV;
    decrypt = 1'b0;
    load    = 1'b1;
    @(posedge clk); #1;
    load      = 1'b0;
    key_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("num_before_abort", 64'(round_num), 64'd5);
    #2 n_rst = 1'b0;
    #1;
    check("abort_round_key", 64'(round_key), 64'd0);
    check("abort_key_valid", 64'(key_valid), 64'd0);
    check("abort_round_num", 64'(round_num), 64'd0);
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_done", 64'(done), 64'd0);
    @(posedge clk); #1;
    check("abort_no_done", 64'(done), 64'd0);
    n_rst     = 1'b1;
    key_ready = 1'b0;
    @(posedge clk); #1;
    run_seq(KV, 1'b0, 0, KV);

    // random keys, directions and ready patterns
    for (int t = 0; t < 4; t++) begin
      rk = {$urandom, $urandom};
      rd = 1'($urandom_range(0, 1));
      run_seq(rk, rd, 2, rk);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
